// File: rtl/gumnut_port_pkg.sv
// Shared widths, register offsets, CTRL bit positions and bus FSM state type
// for the gumnut port responder.
package gumnut_port_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned ADDR_W = 8;
    localparam int unsigned CTRL_W = 3;
    localparam int unsigned WCNT_W = 3;

    localparam logic [2:0] OFS_LED    = 3'd0;
    localparam logic [2:0] OFS_SW     = 3'd1;
    localparam logic [2:0] OFS_CTRL   = 3'd2;
    localparam logic [2:0] OFS_COUNT  = 3'd3;
    localparam logic [2:0] OFS_STATUS = 3'd4;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_AUTO = 1;
    localparam int unsigned CTRL_IRQ  = 2;

    typedef enum logic [1:0] {IDLE, WAIT, ACK, DONE} port_state_t;

endpackage

// File: rtl/gumnut_port_responder_if.sv
// Core I/O port bus: the datapath is the master, the port responder the slave.
interface gumnut_port_responder_if;
    import gumnut_port_pkg::*;

    logic              port_cyc_i;
    logic              port_stb_i;
    logic              port_we_i;
    logic [ADDR_W-1:0] port_adr_i;
    logic [DATA_W-1:0] port_dat_i;
    logic [DATA_W-1:0] port_dat_o;
    logic              port_ack_o;

    modport master (
        output port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
        input  port_dat_o, port_ack_o
    );

    modport slave (
        input  port_cyc_i, port_stb_i, port_we_i, port_adr_i, port_dat_i,
        output port_dat_o, port_ack_o
    );

endinterface

// File: rtl/port_timer.sv
// Prescaled 8-bit down-timer with reload, sticky expiry and CTRL storage.
// CTRL irq-enable bit is only stored when PORT_IRQ_EN is defined.
module port_timer
    import gumnut_port_pkg::*;
#(
    parameter int unsigned PRESCALE = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ctrl_we,
    input  logic              count_we,
    input  logic              status_clr,
    input  logic [DATA_W-1:0] wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [DATA_W-1:0] count,
    output logic              expired
);
    localparam int unsigned     PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
`ifdef PORT_IRQ_EN
    localparam logic [CTRL_W-1:0] CTRL_STORED = 3'b111;
`else
    localparam logic [CTRL_W-1:0] CTRL_STORED = 3'b011;
`endif

    logic [PS_W-1:0]   ps;
    logic [DATA_W-1:0] reload;
    logic              tick_c;
    logic              hit_c;

    // A tick reaching (or starting at) zero expires; a same-edge COUNT write overrides it.
    assign tick_c = ctrl[CTRL_EN] && (ps == PS_LAST);
    assign hit_c  = tick_c && !count_we && (count <= DATA_W'(1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ps <= '0;
        end else if (count_we) begin
            ps <= '0;
        end else if (ctrl[CTRL_EN]) begin
            ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count  <= '0;
            reload <= '0;
        end else if (count_we) begin
            count  <= wdata;
            reload <= wdata;
        end else if (tick_c) begin
            if (count <= DATA_W'(1)) begin
                count <= ctrl[CTRL_AUTO] ? reload : '0;
            end else begin
                count <= count - DATA_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ctrl <= '0;
        end else if (ctrl_we) begin
            ctrl <= wdata[CTRL_W-1:0] & CTRL_STORED;
        end else if (hit_c && !ctrl[CTRL_AUTO]) begin
            ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // Expiry set beats a same-edge STATUS read-clear.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            expired <= 1'b0;
        end else if (hit_c) begin
            expired <= 1'b1;
        end else if (status_clr) begin
            expired <= 1'b0;
        end
    end

endmodule

// File: rtl/gumnut_port_responder.sv
// Port-bus responder: wait-stated single-cycle ack, LED/SW/timer register window.
// Optional irq_o output enabled by defining PORT_IRQ_EN.
module gumnut_port_responder
    import gumnut_port_pkg::*;
#(
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 8'h00,
    parameter int unsigned       WAIT_STATES = 1,
    parameter int unsigned       PRESCALE    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    gumnut_port_responder_if.slave bus,
    input  logic [DATA_W-1:0]      sw_i,
    output logic [DATA_W-1:0]      led_o
`ifdef PORT_IRQ_EN
    ,
    output logic                   irq_o
`endif
);
    localparam logic [WCNT_W-1:0] WCNT_INIT =
        (WAIT_STATES > 0) ? WCNT_W'(WAIT_STATES - 1) : '0;

    port_state_t       state;
    port_state_t       state_nxt;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_nxt;
    logic              req_c;
    logic              commit_c;
    logic              wr_c;
    logic [2:0]        ofs_c;
    logic [DATA_W-1:0] rd_data_c;
    logic [DATA_W-1:0] sw_meta;
    logic [DATA_W-1:0] sw_sync;
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] count;
    logic              expired;

    assign req_c    = bus.port_cyc_i && bus.port_stb_i
                      && (bus.port_adr_i[ADDR_W-1:3] == BASE_ADDR[ADDR_W-1:3]);
    assign ofs_c    = bus.port_adr_i[2:0];
    assign commit_c = (state_nxt == ACK);
    assign wr_c     = commit_c && bus.port_we_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            wcnt  <= '0;
        end else begin
            state <= state_nxt;
            wcnt  <= wcnt_nxt;
        end
    end

    // DONE holds until the strobe drops so a held strobe never gets a second ack.
    always_comb begin
        state_nxt = state;
        wcnt_nxt  = wcnt;
        case (state)
            IDLE: begin
                if (req_c) begin
                    if (WAIT_STATES == 0) begin
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WAIT;
                        wcnt_nxt  = WCNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (!(bus.port_cyc_i && bus.port_stb_i)) begin
                    state_nxt = IDLE;
                end else if (wcnt == '0) begin
                    state_nxt = ACK;
                end else begin
                    wcnt_nxt = wcnt - WCNT_W'(1);
                end
            end
            ACK:     state_nxt = DONE;
            DONE:    if (!bus.port_stb_i) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rd_data_c = '0;
        case (ofs_c)
            OFS_LED:    rd_data_c = led_o;
            OFS_SW:     rd_data_c = sw_sync;
            OFS_CTRL:   rd_data_c = DATA_W'(ctrl);
            OFS_COUNT:  rd_data_c = count;
            OFS_STATUS: rd_data_c = DATA_W'(expired);
            default:    rd_data_c = '0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            bus.port_ack_o <= 1'b0;
            bus.port_dat_o <= '0;
            led_o          <= '0;
            sw_meta        <= '0;
            sw_sync        <= '0;
        end else begin
            bus.port_ack_o <= commit_c;
            bus.port_dat_o <= (commit_c && !bus.port_we_i) ? rd_data_c : '0;
            if (wr_c && (ofs_c == OFS_LED)) led_o <= bus.port_dat_i;
            sw_meta <= sw_i;
            sw_sync <= sw_meta;
        end
    end

    port_timer #(
        .PRESCALE (PRESCALE)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .ctrl_we    (wr_c && (ofs_c == OFS_CTRL)),
        .count_we   (wr_c && (ofs_c == OFS_COUNT)),
        .status_clr (commit_c && !bus.port_we_i && (ofs_c == OFS_STATUS)),
        .wdata      (bus.port_dat_i),
        .ctrl       (ctrl),
        .count      (count),
        .expired    (expired)
    );

`ifdef PORT_IRQ_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) irq_o <= 1'b0;
        else        irq_o <= expired && ctrl[CTRL_IRQ];
    end
`endif

endmodule

// File: tb/tb_gumnut_port_responder.sv
// Scoreboard bench for gumnut_port_responder: randomized register traffic plus
// timed timer, abort and reset scenarios checked against a behavioural model.
module tb_gumnut_port_responder;
    import gumnut_port_pkg::*;

    localparam logic [7:0]  BASE = 8'h40;
    localparam int unsigned WS   = 2;
    localparam int unsigned PS   = 4;
    localparam int          LAT  = int'(WS) + 1;
`ifdef PORT_IRQ_EN
    localparam logic [7:0] CTRL_MASK = 8'h07;
`else
    localparam logic [7:0] CTRL_MASK = 8'h03;
`endif

    typedef struct packed {
        logic       is_read;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_i;
    logic [7:0] sw_i;
    logic [7:0] led_o;
`ifdef PORT_IRQ_EN
    logic       irq_o;
`endif

    gumnut_port_responder_if bus ();

    gumnut_port_responder #(
        .BASE_ADDR   (BASE),
        .WAIT_STATES (WS),
        .PRESCALE    (PS)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .bus   (bus),
        .sw_i  (sw_i),
        .led_o (led_o)
`ifdef PORT_IRQ_EN
        ,
        .irq_o (irq_o)
`endif
    );

    always #5 clk = ~clk;

    int   cyc_n = 0;
    int   total = 0;
    int   bad   = 0;
    int   last_commit = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [7:0] exp_led, exp_ctrl, exp_count;

    always @(posedge clk) cyc_n++;

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
        end
    endfunction

    // Monitor: every ack consumes one scoreboard entry; data must be zero outside ack.
    always @(negedge clk) begin
        if (rst_i === 1'b1) begin
            if (bus.port_ack_o) begin
                if (sb.size() == 0) begin
                    check("ack_without_request", 32'(bus.port_ack_o), 32'd0);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.is_read) check("read_data", 32'(bus.port_dat_o), 32'(mon_e.data));
                end
            end else begin
                check("dat_zero_idle", 32'(bus.port_dat_o), 32'd0);
            end
        end
    end

    task automatic idle_bus();
        bus.port_cyc_i = 1'b0;
        bus.port_stb_i = 1'b0;
        bus.port_we_i  = 1'b0;
    endtask

    task automatic xfer(input bit we, input logic [2:0] ofs, input logic [7:0] wd,
                        input logic [7:0] exp_rd, input int hold);
        int n;
        sb.push_back('{is_read: !we, data: exp_rd});
        bus.port_cyc_i = 1'b1;
        bus.port_stb_i = 1'b1;
        bus.port_we_i  = we;
        bus.port_adr_i = BASE + 8'(ofs);
        bus.port_dat_i = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.port_ack_o && n < 20);
        last_commit = cyc_n;
        check("ack_latency", 32'(n), 32'(LAT));
        if (we && ofs == OFS_LED) check("led_on_ack", 32'(led_o), 32'(wd));
        repeat (hold) @(negedge clk);
        idle_bus();
        repeat (2) @(negedge clk);
    endtask

    task automatic unsel(input logic [7:0] adr);
        bus.port_cyc_i = 1'b1;
        bus.port_stb_i = 1'b1;
        bus.port_we_i  = 1'($urandom);
        bus.port_adr_i = adr;
        bus.port_dat_i = 8'($urandom);
        repeat (LAT + 4) begin
            @(negedge clk);
            check("unsel_no_ack", 32'(bus.port_ack_o), 32'd0);
        end
        idle_bus();
        repeat (2) @(negedge clk);
        check("unsel_led", 32'(led_o), 32'(exp_led));
    endtask

    // Wait so that the next transfer commits exactly on edge 'target'.
    task automatic sched(input int target);
        while (cyc_n < target - LAT) @(negedge clk);
        check("schedule", 32'(cyc_n), 32'(target - LAT));
    endtask

    // One-shot model: a read committing on edge r sees the state after edge r-1.
    function automatic logic [7:0] oneshot_val(input logic [2:0] ofs, input int c0, input int e, input int r);
        int dt, t;
        dt = r - 1 - e;
        t  = dt / int'(PS);
        case (ofs)
            OFS_COUNT:  return (t >= c0) ? 8'd0 : 8'(c0 - t);
            OFS_STATUS: return (dt >= int'(PS) * c0) ? 8'd1 : 8'd0;
            OFS_CTRL:   return (t >= c0) ? 8'd0 : 8'd1;
            default:    return 8'd0;
        endcase
    endfunction

    int ar_e, ar_clr;
    localparam int AR_RELOAD = 2;

    // Auto-reload model: expiry every PS*reload edges; a clear only sticks off expiry edges.
    task automatic ar_status(input int r);
        int per, k, last_exp;
        logic [7:0] e;
        per = int'(PS) * AR_RELOAD;
        k = r - 1 - ar_e;
        last_exp = (k >= per) ? ar_e + (k / per) * per : -1;
        e = (last_exp > ar_clr) ? 8'd1 : 8'd0;
        sched(r);
        xfer(1'b0, OFS_STATUS, 8'h00, e, 0);
        if ((r - ar_e) % per != 0) ar_clr = r;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int e;
        int sel;
        logic [7:0] d;
        logic [7:0] a;
        idle_bus();
        bus.port_adr_i = '0;
        bus.port_dat_i = '0;
        sw_i  = 8'h00;
        rst_i = 1'b0;
        exp_led = 8'h00; exp_ctrl = 8'h00; exp_count = 8'h00;
        #12;
        check("rst_ack", 32'(bus.port_ack_o), 32'd0);
        check("rst_dat", 32'(bus.port_dat_o), 32'd0);
        check("rst_led", 32'(led_o), 32'd0);
`ifdef PORT_IRQ_EN
        check("rst_irq", 32'(irq_o), 32'd0);
`endif
        @(negedge clk);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        xfer(1'b1, OFS_LED, 8'hA5, 8'h00, 0);
        exp_led = 8'hA5;
        xfer(1'b0, OFS_LED, 8'h00, exp_led, 0);
        sw_i = 8'h3C;
        repeat (2) @(negedge clk);
        xfer(1'b0, OFS_SW, 8'h00, 8'h3C, 3);

        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom);
            sel = int'($urandom_range(0, 7));
            case (sel)
                0: begin xfer(1'b1, OFS_LED, d, 8'h00, 0); exp_led = d; end
                1: xfer(1'b0, OFS_LED, 8'h00, exp_led, int'($urandom_range(0, 2)));
                2: begin
                    sw_i = d;
                    if ($urandom_range(0, 1) == 1) xfer(1'b1, OFS_SW, ~d, 8'h00, 0);
                    xfer(1'b0, OFS_SW, 8'h00, d, 0);
                end
                3: begin
                    exp_ctrl = d & 8'hFE & CTRL_MASK;
                    xfer(1'b1, OFS_CTRL, d & 8'hFE, 8'h00, 0);
                    xfer(1'b0, OFS_CTRL, 8'h00, exp_ctrl, 0);
                end
                4: begin
                    exp_count = d;
                    xfer(1'b1, OFS_COUNT, d, 8'h00, 0);
                    xfer(1'b0, OFS_COUNT, 8'h00, exp_count, 0);
                end
                5: begin
                    xfer(1'b1, OFS_STATUS, d, 8'h00, 0);
                    xfer(1'b0, OFS_STATUS, 8'h00, 8'h00, 0);
                end
                6: begin
                    a = 8'($urandom_range(5, 7));
                    xfer(1'b1, a[2:0], d, 8'h00, 0);
                    xfer(1'b0, a[2:0], 8'h00, 8'h00, 0);
                end
                default: begin
                    a = 8'($urandom);
                    if (a[7:3] == BASE[7:3]) a[7] = ~a[7];
                    unsel(a);
                end
            endcase
            check("led_track", 32'(led_o), 32'(exp_led));
        end

        // Abort: strobe dropped during WAIT leaves LED untouched and is never acked.
        bus.port_cyc_i = 1'b1;
        bus.port_stb_i = 1'b1;
        bus.port_we_i  = 1'b1;
        bus.port_adr_i = BASE;
        bus.port_dat_i = ~exp_led;
        @(negedge clk);
        bus.port_stb_i = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_led", 32'(led_o), 32'(exp_led));
        idle_bus();
        @(negedge clk);
        unsel(BASE + 8'd8);

        // One-shot: COUNT=3, enable; expires 3*PS edges after the enable write.
        xfer(1'b1, OFS_COUNT, 8'd3, 8'h00, 0);
        xfer(1'b1, OFS_CTRL, 8'h01, 8'h00, 0);
        e = last_commit;
        sched(e + 6);  xfer(1'b0, OFS_COUNT,  8'h00, oneshot_val(OFS_COUNT, 3, e, e + 6), 0);
        sched(e + 11); xfer(1'b0, OFS_STATUS, 8'h00, oneshot_val(OFS_STATUS, 3, e, e + 11), 0);
        sched(e + 16); xfer(1'b0, OFS_STATUS, 8'h00, oneshot_val(OFS_STATUS, 3, e, e + 16), 0);
        sched(e + 21); xfer(1'b0, OFS_CTRL,   8'h00, oneshot_val(OFS_CTRL, 3, e, e + 21), 0);
        sched(e + 26); xfer(1'b0, OFS_COUNT,  8'h00, oneshot_val(OFS_COUNT, 3, e, e + 26), 0);
        xfer(1'b0, OFS_STATUS, 8'h00, 8'h00, 0);

        // Auto-reload: expiry every PS*2 edges; one read lands exactly on an expiry edge.
        xfer(1'b1, OFS_COUNT, 8'(AR_RELOAD), 8'h00, 0);
        xfer(1'b1, OFS_CTRL, 8'h03, 8'h00, 0);
        ar_e = last_commit;
        ar_clr = ar_e;
        ar_status(ar_e + 12);
        ar_status(ar_e + 19);
        ar_status(ar_e + 24);
        ar_status(ar_e + 29);
        sched(ar_e + 38);
        xfer(1'b0, OFS_COUNT, 8'h00,
             8'(AR_RELOAD - ((ar_e + 37 - ar_e) / int'(PS)) % AR_RELOAD), 0);
        xfer(1'b1, OFS_CTRL, 8'h00, 8'h00, 0);
        xfer(1'b0, OFS_STATUS, 8'h00, 8'h01, 0);

`ifdef PORT_IRQ_EN
        xfer(1'b1, OFS_COUNT, 8'd1, 8'h00, 0);
        xfer(1'b1, OFS_CTRL, 8'h05, 8'h00, 0);
        e = last_commit;
        while (cyc_n < e + int'(PS) + 2) @(negedge clk);
        check("irq_set", 32'(irq_o), 32'd1);
        xfer(1'b0, OFS_STATUS, 8'h00, 8'h01, 0);
        check("irq_cleared", 32'(irq_o), 32'd0);
        xfer(1'b0, OFS_CTRL, 8'h00, 8'h04, 0);
`endif

        // Reset in the middle of a WAIT with the timer running.
        xfer(1'b1, OFS_LED, 8'hC3, 8'h00, 0);
        exp_led = 8'hC3;
        xfer(1'b1, OFS_COUNT, 8'd9, 8'h00, 0);
        xfer(1'b1, OFS_CTRL, 8'h01, 8'h00, 0);
        repeat (5) @(negedge clk);
        bus.port_cyc_i = 1'b1;
        bus.port_stb_i = 1'b1;
        bus.port_we_i  = 1'b1;
        bus.port_adr_i = BASE;
        bus.port_dat_i = 8'h77;
        @(negedge clk);
        #1 rst_i = 1'b0;
        #1;
        check("midrst_ack", 32'(bus.port_ack_o), 32'd0);
        check("midrst_dat", 32'(bus.port_dat_o), 32'd0);
        check("midrst_led", 32'(led_o), 32'd0);
`ifdef PORT_IRQ_EN
        check("midrst_irq", 32'(irq_o), 32'd0);
`endif
        idle_bus();
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        exp_led = 8'h00;
        @(negedge clk);
        xfer(1'b0, OFS_LED,    8'h00, 8'h00, 0);
        xfer(1'b0, OFS_COUNT,  8'h00, 8'h00, 0);
        xfer(1'b0, OFS_CTRL,   8'h00, 8'h00, 0);
        xfer(1'b0, OFS_STATUS, 8'h00, 8'h00, 0);
        xfer(1'b1, OFS_LED,    8'h81, 8'h00, 0);
        exp_led = 8'h81;
        xfer(1'b0, OFS_LED,    8'h00, exp_led, 0);
        repeat (4) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
